// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: initiator side of the ALU start/done handshake.
// Commands are buffered in a small FIFO, issued one at a time with operands held stable,
// and each result (or timeout) is returned on a valid/ready response stream.
// Optional statistics counters are enabled with `define ALU_CMD_DRIVER_STATS_EN.
module alu_cmd_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
`ifdef ALU_CMD_DRIVER_STATS_EN
  output logic [15:0] stat_done_cnt,
  output logic [15:0] stat_timeout_cnt,
`endif
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRelease, StResp} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     res_q, res_d;
  logic            to_q, to_d;
  logic [7:0]      alu_a_q, alu_b_q;
  logic [2:0]      alu_op_q;

  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [18:0]     mem_q [DEPTH];
  logic [18:0]     head;
  logic            empty, full, push, pop;

  // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage, entries packed as {op, a, b}; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // FIFO pointers; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Next-state logic: issue, wait for done or timeout, mandatory start-low cycle, respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    to_d    = to_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (alu_op_q == 3'b000) begin
          // nop: one start cycle, done not required and ignored
          res_d   = '0;
          to_d    = 1'b0;
          state_d = StRelease;
        end else if (alu_done) begin
          res_d   = alu_result;
          to_d    = 1'b0;
          state_d = StRelease;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StRelease: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, wait counter, captured result and operand registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      res_q    <= '0;
      to_q     <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      to_q    <= to_d;
      if (pop) begin
        {alu_op_q, alu_a_q, alu_b_q} <= head;
      end
    end
  end

  // Operands stay loaded from pop until the next pop, so rsp_op can reuse alu_op_q.
  always_comb begin
    alu_a       = alu_a_q;
    alu_b       = alu_b_q;
    alu_op      = alu_op_q;
    alu_start   = (state_q == StIssue);
    rsp_valid   = (state_q == StResp);
    rsp_result  = res_q;
    rsp_op      = alu_op_q;
    rsp_timeout = to_q;
    busy        = (state_q != StIdle) || !empty;
  end

`ifdef ALU_CMD_DRIVER_STATS_EN
  logic [15:0] done_cnt_q, to_cnt_q;

  // Saturating completion counters, stepped on each response handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (to_q) begin
        if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
      end else begin
        if (done_cnt_q != 16'hFFFF) done_cnt_q <= done_cnt_q + 16'd1;
      end
    end
  end

  assign stat_done_cnt    = done_cnt_q;
  assign stat_timeout_cnt = to_cnt_q;
`endif

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the ALU start/done handshake. Buffers operation commands from a valid/ready stream, drives A/B/op/start toward the ALU, and waits for done. Captures the 16-bit result and returns it on a valid/ready response stream.
- Sits between the test stimulus or host logic and the ALU. Owns protocol compliance: stable operands, start release after done, and timeout on a missing done.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2)
- TIMEOUT, 16, max cycles start may stay high without done before the op is aborted

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  3  opcode: 000 nop, 001 add, 010 and, 011 xor, 1xx mul
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_op  out  3  to ALU op
- alu_start  out  1  to ALU start
- alu_done  in  1  from ALU done
- alu_result  in  16  from ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_result  out  16  captured result (0 for nop and timeout)
- rsp_op  out  3  opcode of completed command
- rsp_timeout  out  1  op aborted by timeout
- busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset: clk and reset_n are the clock and reset; reset_n is synchronous, active-low. Reset clears the FIFO and enters IDLE. All outputs reset to 0 except cmd_ready, which is 1 after the first reset cycle.
- Reset mid-operation drops alu_start in the next cycle and discards in-flight and queued commands. No response is generated for discarded commands.
- FIFO write: a command is written when cmd_valid && cmd_ready. cmd_ready = !full.
- FIFO read: occurs on the IDLE->ISSUE transition. Simultaneous read and write while full is not permitted, because cmd_ready is 0 when full.
- Write and read pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.
- IDLE: if the FIFO is not empty, pop the head and load the alu_a/alu_b/alu_op registers; next state is ISSUE.
- ISSUE: alu_start=1. alu_a, alu_b and alu_op are held constant for the whole of ISSUE. A wait counter increments each cycle.
  - nop (op 000): start is held exactly 1 cycle, then go to RELEASE with result 0 and timeout 0. alu_done is not required.
  - otherwise, when alu_done=1: capture alu_result in the same cycle and go to RELEASE.
  - If the counter reaches TIMEOUT before alu_done: go to RELEASE with result 0 and timeout 1.
  - alu_done is ignored in every state except ISSUE.
- RELEASE: alu_start=0 for exactly 1 cycle. This is mandatory, so the multiplier pipeline is not re-triggered by a start held after done. Operands remain held. Next state is RESP.
- RESP: rsp_valid=1 with rsp_result/rsp_op/rsp_timeout stable until rsp_valid && rsp_ready. On the handshake, go to IDLE.
- Latency: cmd handshake at cycle N gives earliest alu_start at N+2 (FIFO write at N, pop at N+1). Earliest rsp_valid is done cycle +2.
- Throughput: one op in flight. A new start never asserts while rsp_valid=1.
- Width rules: rsp_result is exactly alu_result as captured, with no extension or truncation. The op[2]=1 variants 101-111 are forwarded unchanged and treated as multiply.
- busy = (state!=IDLE) || !empty.

Optional Feature:
- Macro: ALU_CMD_DRIVER_STATS_EN.
- When defined, add outputs:
  - stat_done_cnt [15:0]: increments on each RESP handshake with rsp_timeout=0.
  - stat_timeout_cnt [15:0]: increments on each RESP handshake with rsp_timeout=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- add A=8'hFF B=8'h01, ALU done 1 cycle after start -> alu_start high 1-2 cycles then low for 1 cycle; response result 16'h0100, op 001, timeout 0.
- mul A=8'hFF B=8'hFF, done 5 cycles after start -> start held all 5 cycles, operands stable; response 16'hFE01 after RELEASE.
- nop A=8'h12 B=8'h34 with alu_done tied 0 -> start pulses exactly 1 cycle; response result 16'h0000, timeout 0.
- alu_done tied 0, xor op, TIMEOUT=16 -> start drops after 16 cycles; response result 0, timeout 1 (and stat_timeout_cnt=1 when stats enabled).
- rsp_ready held 0 while DEPTH=4 commands plus one more are offered -> cmd_ready=0 after FIFO full; no new start while rsp_valid; all 5 responses return in order (and, add, xor, mul, and) once rsp_ready=1.
- reset_n low for 1 cycle during ISSUE of a mul with 2 queued -> start=0 next cycle, rsp_valid=0, busy=0, FIFO empty; no responses for the discarded commands.
